// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with valid/ready on every port and a registered output.
// Define RR_ARB_MUX_SKID_EN to add a 2-entry skid buffer that removes the out_ready -> in_ready path.
module rr_arb_mux #(
    parameter  int N_CH  = 3,
    parameter  int WIDTH = 32,
    localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CHW-1:0]        out_ch
);

    logic [CHW-1:0]   ptr_q, ptr_d;
    logic [N_CH-1:0]  grant;
    logic [CHW-1:0]   gnt_idx;
    logic             found;
    logic             free;
    logic [WIDTH-1:0] sel_data;
    int               idx;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CHW-1:0]   out_ch_q, out_ch_d;

    // Search starts at the pointer and wraps, so the channel after the last winner has top priority.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        sel_data = '0;
        idx      = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(ptr_q) + k) % N_CH;
            if (free && !found && in_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gnt_idx     = CHW'(idx);
                sel_data    = in_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == CHW'(N_CH - 1)) ? '0 : gnt_idx + CHW'(1);
        end
    end

    assign in_ready = grant & {N_CH{rst_n}};
    assign out_data = out_data_q;
    assign out_ch   = out_ch_q;

`ifdef RR_ARB_MUX_SKID_EN
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CHW-1:0]   skid_ch_q, skid_ch_d;
    logic             pop;

    // Free depends only on registered occupancy, keeping out_ready out of the in_ready cone.
    assign free      = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_d       = occ_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        skid_data_d = skid_data_q;
        skid_ch_d   = skid_ch_q;
        case (occ_q)
            2'd0: begin
                if (found) begin
                    out_data_d = sel_data;
                    out_ch_d   = gnt_idx;
                    occ_d      = 2'd1;
                end
            end
            2'd1: begin
                if (found && pop) begin
                    out_data_d = sel_data;
                    out_ch_d   = gnt_idx;
                end else if (found) begin
                    skid_data_d = sel_data;
                    skid_ch_d   = gnt_idx;
                    occ_d       = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    out_data_d = skid_data_q;
                    out_ch_d   = skid_ch_q;
                    occ_d      = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= 2'd0;
            skid_data_q <= '0;
            skid_ch_q   <= '0;
        end else begin
            occ_q       <= occ_d;
            skid_data_q <= skid_data_d;
            skid_ch_q   <= skid_ch_d;
        end
    end
`else
    logic out_valid_q, out_valid_d;

    assign free      = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (found) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (N_CH=3, WIDTH=32): directed vector table,
// hand sequences for reset/backpressure/skid corners, and randomized traffic vs a queue model.
module tb_rr_arb_mux;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_ch;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb_mux #(.N_CH(3), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          ch;
    } beat_t;

    beat_t       mq[$];
    int          m_ptr;
    logic [31:0] m_last_data;
    int          m_last_ch;

`ifdef RR_ARB_MUX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ptr       = 0;
        m_last_data = '0;
        m_last_ch   = 0;
    endtask

    // Drive one cycle from a negedge: check against the model, take the edge, advance the model.
    task automatic step(input logic [2:0] v, input logic r, input logic [95:0] d);
        bit          free;
        int          g;
        logic [2:0]  exp_rdy;
        beat_t       b;
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        #1;
        free = (CAP == 1) ? ((mq.size() == 0) || r) : (mq.size() < CAP);
        g = -1;
        if (free) begin
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
        end
        exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), (mq.size() > 0) ? 32'd1 : 32'd0);
        chk("out_data", out_data, (mq.size() > 0) ? mq[0].data : m_last_data);
        chk("out_ch", 32'(out_ch), (mq.size() > 0) ? 32'(mq[0].ch) : 32'(m_last_ch));
        @(posedge clk);
        if (mq.size() > 0 && r) void'(mq.pop_front());
        if (g >= 0) begin
            b.data = d[g*32 +: 32];
            b.ch   = g;
            mq.push_back(b);
            m_ptr = (g + 1) % 3;
        end
        if (mq.size() > 0) begin
            m_last_data = mq[0].data;
            m_last_ch   = mq[0].ch;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [2:0]  v;
        logic        r;
        logic [2:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_ch;
        logic [31:0] exp_data;
    } vec_t;

    localparam logic [95:0] ECHO = {32'hA2, 32'hA1, 32'hA0};

    initial begin
        vec_t        vt[13];
        logic [95:0] rd;
        logic [31:0] held;

        do_reset();

`ifndef RR_ARB_MUX_SKID_EN
        // Rotation, skip-idle, idle with held pointer, refill without out_ready.
        vt[0]  = '{3'b111, 1'b1, 3'b001, 1'b0, 2'd0, 32'h0};
        vt[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 32'hA0};
        vt[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 32'hA1};
        vt[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 32'hA2};
        vt[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 32'hA0};
        vt[5]  = '{3'b001, 1'b1, 3'b001, 1'b1, 2'd1, 32'hA1};
        vt[6]  = '{3'b110, 1'b1, 3'b010, 1'b1, 2'd0, 32'hA0};
        vt[7]  = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd1, 32'hA1};
        vt[8]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd1, 32'hA1};
        vt[9]  = '{3'b000, 1'b0, 3'b000, 1'b0, 2'd1, 32'hA1};
        vt[10] = '{3'b110, 1'b0, 3'b100, 1'b0, 2'd1, 32'hA1};
        vt[11] = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd2, 32'hA2};
        vt[12] = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 32'hA2};
        for (int i = 0; i < 13; i++) begin
            in_valid  = vt[i].v;
            out_ready = vt[i].r;
            in_data   = ECHO;
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vt[i].exp_rdy));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].exp_ov));
            chk($sformatf("vec%0d out_ch", i), 32'(out_ch), 32'(vt[i].exp_ch));
            chk($sformatf("vec%0d out_data", i), out_data, vt[i].exp_data);
            @(negedge clk);
        end

        // Backpressure: hold DEAD_BEEF for 5 cycles, then drain and refill on one edge.
        do_reset();
        step(3'b001, 1'b1, {32'h2, 32'h1, 32'hDEAD_BEEF});
        for (int i = 0; i < 5; i++) begin
            step(3'b111, 1'b0, {32'hC2, 32'hC1, 32'hC0});
            chk("bp out_data", out_data, 32'hDEAD_BEEF);
            chk("bp out_ch", 32'(out_ch), 32'd0);
        end
        step(3'b111, 1'b1, {32'hC2, 32'hC1, 32'hC0});
        #1;
        chk("bp refill out_data", out_data, 32'hC1);
        chk("bp refill out_valid", 32'(out_valid), 32'd1);
`else
        // Fill both entries with the sink stalled, then release and check order.
        do_reset();
        step(3'b001, 1'b0, {32'h0, 32'h0, 32'h5A01});
        step(3'b010, 1'b0, {32'h0, 32'h5A02, 32'h0});
        #1;
        in_valid = 3'b111;
        #1;
        chk("skid full in_ready", 32'(in_ready), 32'd0);
        chk("skid head data", out_data, 32'h5A01);
        @(negedge clk);
        step(3'b000, 1'b1, '0);
        #1;
        chk("skid second data", out_data, 32'h5A02);
        chk("skid second ch", 32'(out_ch), 32'd1);
        @(negedge clk);
        step(3'b000, 1'b1, '0);
        #1;
        chk("skid empty", 32'(out_valid), 32'd0);
        @(negedge clk);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom(), $urandom(), $urandom()};
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), rd);
        end

        // Asynchronous reset mid-stream with a beat held.
        step(3'b111, 1'b0, {32'h33, 32'h22, 32'h11});
        step(3'b111, 1'b0, {32'h33, 32'h22, 32'h11});
        held = out_data;
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        in_valid = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_ch", 32'(out_ch), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        if (held == 32'h0) chk("pre-reset data nonzero", held, 32'h11);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(3'b100, 1'b1, {32'h77, 32'h66, 32'h55});
        step(3'b000, 1'b1, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
